// File: rtl/snake_pkg.sv
// Shared constants, state encoding and coordinate payload for the snake game datapath.
package snake_pkg;

    localparam int unsigned GRID      = 10;
    localparam int unsigned X_MIN     = 90;
    localparam int unsigned X_MAX     = 350;
    localparam int unsigned Y_MIN     = 90;
    localparam int unsigned Y_MAX     = 350;
    localparam int unsigned X_W       = 10;
    localparam int unsigned Y_W       = 9;
    localparam int unsigned MAX_LEN   = 64;
    localparam int unsigned MAX_TRIES = 16;
    localparam int unsigned ADDR_W    = $clog2(MAX_LEN);
    localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1);
    localparam int unsigned TRY_W     = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SCAN,
        COMMIT,
        FAIL
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } coord_t;

endpackage

// File: rtl/food_spawner_if.sv
// Request, random-sample, body-memory and food-position signals of the food spawner.
interface food_spawner_if;
    import snake_pkg::*;

    logic              spawn_req;
    logic [X_W-1:0]    rand_x;
    logic [Y_W-1:0]    rand_y;
    logic [LEN_W-1:0]  snake_len;
    logic [ADDR_W-1:0] seg_addr;
    logic [X_W-1:0]    seg_x;
    logic [Y_W-1:0]    seg_y;
    logic [X_W-1:0]    food_x;
    logic [Y_W-1:0]    food_y;
    logic              food_valid;
    logic              busy;
    logic              spawn_done;
    logic              spawn_fail;

    // master: game logic, random source and body store; slave: the spawner
    modport master (
        output spawn_req, rand_x, rand_y, snake_len, seg_x, seg_y,
        input  seg_addr, food_x, food_y, food_valid, busy, spawn_done, spawn_fail
    );

    modport slave (
        input  spawn_req, rand_x, rand_y, snake_len, seg_x, seg_y,
        output seg_addr, food_x, food_y, food_valid, busy, spawn_done, spawn_fail
    );

endinterface

// File: rtl/grid_snap.sv
// One-axis snap of a raw sample down to the grid anchored at MIN, plus legality check.
module grid_snap
    import snake_pkg::*;
#(
    parameter int unsigned W     = X_W,
    parameter int unsigned MIN   = X_MIN,
    parameter int unsigned MAX   = X_MAX,
    parameter int unsigned PITCH = GRID
) (
    input  logic [W-1:0] raw,
    output logic [W-1:0] snapped_c,
    output logic         in_range_c
);

    logic [W:0] offset;
    logic [W:0] rem;

    // offset is garbage when raw < MIN, but that case is rejected anyway
    always_comb begin
        offset     = {1'b0, raw} - (W+1)'(MIN);
        rem        = offset % (W+1)'(PITCH);
        snapped_c  = W'({1'b0, raw} - rem);
        in_range_c = (raw >= W'(MIN)) && (snapped_c <= W'(MAX));
    end

endmodule

// File: rtl/food_spawner.sv
// Picks a free, grid-aligned food cell from random samples, retrying on body collisions.
module food_spawner
    import snake_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    food_spawner_if.slave bus
);

    state_t            state, state_n;
    logic [LEN_W-1:0]  n_len, n_len_n;
    logic [TRY_W-1:0]  tries, tries_n;
    coord_t            cand, cand_n;
    logic [ADDR_W-1:0] seg_addr, seg_addr_n;
    logic [ADDR_W-1:0] cmp_idx, cmp_idx_n;
    logic              rd_valid, rd_valid_n;
    logic [X_W-1:0]    food_x, food_x_n;
    logic [Y_W-1:0]    food_y, food_y_n;
    logic              food_valid, food_valid_n;
    logic              busy, busy_n;
    logic              spawn_done, spawn_done_n;
    logic              spawn_fail, spawn_fail_n;

    logic [X_W-1:0]    snap_x_c;
    logic [Y_W-1:0]    snap_y_c;
    logic              ok_x_c, ok_y_c;
    logic [ADDR_W-1:0] last_idx_c;
    logic              hit_c;

    grid_snap #(.W(X_W), .MIN(X_MIN), .MAX(X_MAX), .PITCH(GRID)) u_snap_x (
        .raw        (bus.rand_x),
        .snapped_c  (snap_x_c),
        .in_range_c (ok_x_c)
    );

    grid_snap #(.W(Y_W), .MIN(Y_MIN), .MAX(Y_MAX), .PITCH(GRID)) u_snap_y (
        .raw        (bus.rand_y),
        .snapped_c  (snap_y_c),
        .in_range_c (ok_y_c)
    );

    // rd_valid marks that seg_x/seg_y belong to body index cmp_idx
    assign last_idx_c = ADDR_W'(n_len - LEN_W'(1));
    assign hit_c      = rd_valid && (bus.seg_x == cand.x) && (bus.seg_y == cand.y);

    always_comb begin
        state_n      = state;
        n_len_n      = n_len;
        tries_n      = tries;
        cand_n       = cand;
        seg_addr_n   = seg_addr;
        cmp_idx_n    = cmp_idx;
        rd_valid_n   = rd_valid;
        food_x_n     = food_x;
        food_y_n     = food_y;
        food_valid_n = food_valid;
        spawn_done_n = 1'b0;
        spawn_fail_n = 1'b0;

        unique case (state)
            IDLE: begin
                // the cycle carrying a done/fail pulse still refuses new requests
                if (bus.spawn_req && !spawn_done && !spawn_fail) begin
                    n_len_n = bus.snake_len;
                    tries_n = '0;
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                tries_n  = tries + TRY_W'(1);
                cand_n.x = snap_x_c;
                cand_n.y = snap_y_c;
                if (!(ok_x_c && ok_y_c)) begin
                    state_n = (tries_n < TRY_W'(MAX_TRIES)) ? SAMPLE : FAIL;
                end else if (n_len == '0) begin
                    state_n = COMMIT;
                end else begin
                    state_n    = SCAN;
                    seg_addr_n = '0;
                    cmp_idx_n  = '0;
                    rd_valid_n = 1'b0;
                end
            end
            SCAN: begin
                if (seg_addr < last_idx_c) begin
                    seg_addr_n = seg_addr + ADDR_W'(1);
                end
                rd_valid_n = 1'b1;
                if (hit_c) begin
                    state_n    = (tries < TRY_W'(MAX_TRIES)) ? SAMPLE : FAIL;
                    rd_valid_n = 1'b0;
                end else if (rd_valid && (cmp_idx == last_idx_c)) begin
                    state_n    = COMMIT;
                    rd_valid_n = 1'b0;
                end else if (rd_valid) begin
                    cmp_idx_n = cmp_idx + ADDR_W'(1);
                end
            end
            COMMIT: begin
                food_x_n     = cand.x;
                food_y_n     = cand.y;
                food_valid_n = 1'b1;
                spawn_done_n = 1'b1;
                state_n      = IDLE;
            end
            FAIL: begin
                food_valid_n = 1'b0;
                spawn_fail_n = 1'b1;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            n_len      <= '0;
            tries      <= '0;
            cand       <= '0;
            seg_addr   <= '0;
            cmp_idx    <= '0;
            rd_valid   <= 1'b0;
            food_x     <= X_W'(X_MIN);
            food_y     <= Y_W'(Y_MIN);
            food_valid <= 1'b0;
            busy       <= 1'b0;
            spawn_done <= 1'b0;
            spawn_fail <= 1'b0;
        end else begin
            state      <= state_n;
            n_len      <= n_len_n;
            tries      <= tries_n;
            cand       <= cand_n;
            seg_addr   <= seg_addr_n;
            cmp_idx    <= cmp_idx_n;
            rd_valid   <= rd_valid_n;
            food_x     <= food_x_n;
            food_y     <= food_y_n;
            food_valid <= food_valid_n;
            busy       <= busy_n;
            spawn_done <= spawn_done_n;
            spawn_fail <= spawn_fail_n;
        end
    end

    assign bus.seg_addr   = seg_addr;
    assign bus.food_x     = food_x;
    assign bus.food_y     = food_y;
    assign bus.food_valid = food_valid;
    assign bus.busy       = busy;
    assign bus.spawn_done = spawn_done;
    assign bus.spawn_fail = spawn_fail;

endmodule

// File: tb/tb_food_spawner.sv
// Randomized bench for food_spawner against a latency/result model derived from the placement rules.
module tb_food_spawner;
    import snake_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    food_spawner_if bus();

    food_spawner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [9:0] mem_x [64];
    logic [8:0] mem_y [64];

    // body store with one-cycle synchronous read
    always @(posedge clk) begin
        bus.seg_x <= mem_x[bus.seg_addr];
        bus.seg_y <= mem_y[bus.seg_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int sx [16];
    int sy [16];
    int samp_edge [16];
    int m_fx = 90;
    int m_fy = 90;
    bit m_fv = 1'b0;
    int last_lat;
    int addr_seq [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_snap(input int r, input int lo, input int hi,
                                       output int s, output bit ok);
        if (r < lo) begin
            s  = 0;
            ok = 1'b0;
        end else begin
            s  = r - ((r - lo) % 10);
            ok = (s <= hi);
        end
    endfunction

    // Walk the candidate list: each try costs 1 edge if illegal, k+3 if the first body hit is at k.
    task automatic predict(input int n, output int done_e, output bit ok,
                           output int ex, output int ey);
        int e, cx, cy, k;
        bit okx, oky;
        e = 1; ok = 1'b0; ex = 0; ey = 0; done_e = -1;
        for (int t = 0; t < 16; t++) samp_edge[t] = -1;
        for (int t = 0; t < 16; t++) begin
            samp_edge[t] = e;
            model_snap(sx[t], 90, 350, cx, okx);
            model_snap(sy[t], 90, 350, cy, oky);
            if (!(okx && oky)) begin
                e += 1;
            end else begin
                k = -1;
                for (int j = 0; j < n; j++)
                    if (k < 0 && int'(mem_x[j]) == cx && int'(mem_y[j]) == cy) k = j;
                if (k < 0) begin
                    ok = 1'b1; ex = cx; ey = cy;
                    done_e = (n == 0) ? e + 1 : e + n + 2;
                    break;
                end
                e += k + 3;
            end
        end
        if (!ok) done_e = e;
    endtask

    task automatic gen_body();
        for (int j = 0; j < 64; j++) begin
            mem_x[j] = 10'(90 + 10 * int'($urandom_range(0, 26)));
            mem_y[j] = 9'(90 + 10 * int'($urandom_range(0, 26)));
        end
    endtask

    task automatic gen_samples(input int n);
        int mode, j;
        for (int t = 0; t < 16; t++) begin
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                sx[t] = int'($urandom_range(0, 1023));
                sy[t] = int'($urandom_range(0, 511));
            end else if (mode == 1 && n > 0) begin
                j = int'($urandom_range(0, n - 1));
                sx[t] = int'(mem_x[j]) + int'($urandom_range(0, 9));
                sy[t] = int'(mem_y[j]) + int'($urandom_range(0, 9));
            end else begin
                sx[t] = int'($urandom_range(90, 359));
                sy[t] = int'($urandom_range(90, 359));
            end
        end
    endtask

    task automatic run_spawn(input string tag, input int n, input bit scramble);
        int done_e, ex, ey, ecnt, t;
        bit ok, got;
        predict(n, done_e, ok, ex, ey);
        @(negedge clk);
        bus.spawn_req = 1'b1;
        bus.snake_len = 7'(n);
        bus.rand_x    = 10'(sx[0]);
        bus.rand_y    = 9'(sy[0]);
        @(posedge clk);
        #1 bus.spawn_req = 1'b0;
        ecnt = 0; t = 0; got = 1'b0;
        addr_seq.delete();
        while (ecnt < 2000 && !got) begin
            @(posedge clk);
            #1 ecnt++;
            if (addr_seq.size() == 0 || addr_seq[$] != int'(bus.seg_addr))
                addr_seq.push_back(int'(bus.seg_addr));
            got = bus.spawn_done || bus.spawn_fail;
            if (!got) begin
                if (scramble) bus.snake_len = 7'($urandom_range(0, 64));
                bus.spawn_req = (ecnt == 1);
                if (t < 15 && ecnt == samp_edge[t]) begin
                    t++;
                    bus.rand_x = 10'(sx[t]);
                    bus.rand_y = 9'(sy[t]);
                end
            end
        end
        last_lat = ecnt;
        check_eq({tag, "_latency"}, 64'(ecnt), 64'(done_e));
        check_eq({tag, "_done"}, 64'(bus.spawn_done), 64'(ok));
        check_eq({tag, "_fail"}, 64'(bus.spawn_fail), 64'(!ok));
        if (ok) begin
            m_fx = ex; m_fy = ey; m_fv = 1'b1;
        end else begin
            m_fv = 1'b0;
        end
        check_eq({tag, "_food_x"}, 64'(bus.food_x), 64'(m_fx));
        check_eq({tag, "_food_y"}, 64'(bus.food_y), 64'(m_fy));
        check_eq({tag, "_valid"}, 64'(bus.food_valid), 64'(m_fv));
        check_eq({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        // a request alongside the completion pulse must not start another spawn
        bus.spawn_req = 1'b1;
        @(posedge clk);
        #1 bus.spawn_req = 1'b0;
        check_eq({tag, "_pulse_end"}, 64'(bus.spawn_done || bus.spawn_fail), 64'd0);
        check_eq({tag, "_b2b_ignored"}, 64'(bus.busy), 64'd0);
    endtask

    logic [35:0] seq_packed;
    bit          found;

    initial begin
        reset = 1'b1;
        bus.spawn_req = 1'b0;
        bus.rand_x = '0;
        bus.rand_y = '0;
        bus.snake_len = '0;
        gen_body();
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_food_x", 64'(bus.food_x), 64'd90);
        check_eq("rst_food_y", 64'(bus.food_y), 64'd90);
        check_eq("rst_valid", 64'(bus.food_valid), 64'd0);
        check_eq("rst_addr", 64'(bus.seg_addr), 64'd0);
        check_eq("rst_pulses", 64'({bus.spawn_done, bus.spawn_fail}), 64'd0);
        reset = 1'b0;

        // snap with an empty body
        sx[0] = 137; sy[0] = 212;
        for (int t = 1; t < 16; t++) begin sx[t] = 200; sy[t] = 200; end
        run_spawn("snap", 0, 1'b0);
        check_eq("snap_x_const", 64'(bus.food_x), 64'd130);
        check_eq("snap_y_const", 64'(bus.food_y), 64'd210);
        check_eq("snap_lat_const", 64'(last_lat), 64'd2);

        // collision at index 2, then a free cell
        mem_x[0] = 10'd100; mem_y[0] = 9'd100;
        mem_x[1] = 10'd110; mem_y[1] = 9'd110;
        mem_x[2] = 10'd130; mem_y[2] = 9'd210;
        sx[0] = 137; sy[0] = 212;
        sx[1] = 255; sy[1] = 101;
        run_spawn("retry", 3, 1'b1);
        check_eq("retry_x_const", 64'(bus.food_x), 64'd250);
        check_eq("retry_y_const", 64'(bus.food_y), 64'd100);
        seq_packed = '0;
        for (int i = 0; i < 6; i++)
            if (i < addr_seq.size()) seq_packed = {seq_packed[29:0], 6'(addr_seq[i])};
        check_eq("retry_addr_len", 64'(addr_seq.size()), 64'd6);
        check_eq("retry_addr_seq", 64'(seq_packed), {28'd0, 6'd0, 6'd1, 6'd2, 6'd0, 6'd1, 6'd2});

        // two out-of-range samples before a legal corner cell
        sx[0] = 89;  sy[0] = 100;
        sx[1] = 400; sy[1] = 100;
        sx[2] = 90;  sy[2] = 90;
        run_spawn("range", 0, 1'b0);
        check_eq("range_lat_const", 64'(last_lat), 64'd4);
        check_eq("range_x_const", 64'(bus.food_x), 64'd90);

        // every candidate lands on the only body cell
        mem_x[0] = 10'd250; mem_y[0] = 9'd200;
        for (int t = 0; t < 16; t++) begin
            sx[t] = 250 + int'($urandom_range(0, 9));
            sy[t] = 200 + int'($urandom_range(0, 9));
        end
        run_spawn("exhaust", 1, 1'b0);
        check_eq("exhaust_lat_const", 64'(last_lat), 64'd49);
        check_eq("exhaust_keep_x", 64'(bus.food_x), 64'd90);

        // reset while scanning a long body
        gen_body();
        for (int j = 0; j < 64; j++) mem_y[j] = 9'd100;
        @(negedge clk);
        bus.spawn_req = 1'b1; bus.snake_len = 7'd20;
        bus.rand_x = 10'd200; bus.rand_y = 9'd300;
        @(posedge clk);
        #1 bus.spawn_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1 if (bus.seg_addr == 6'd5) found = 1'b1;
        end
        check_eq("mid_reach_addr5", 64'(found), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_busy", 64'(bus.busy), 64'd0);
        check_eq("mid_food_x", 64'(bus.food_x), 64'd90);
        check_eq("mid_food_y", 64'(bus.food_y), 64'd90);
        check_eq("mid_valid", 64'(bus.food_valid), 64'd0);
        check_eq("mid_addr", 64'(bus.seg_addr), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_fx = 90; m_fy = 90; m_fv = 1'b0;
        gen_samples(20);
        run_spawn("after_rst", 20, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? 64 : int'($urandom_range(0, 12));
            gen_body();
            gen_samples(n);
            run_spawn("rand", n, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/food_spawner.md
# food_spawner

Consumer of the LFSR coordinate stream: on a spawn request it samples the random X/Y pair, snaps it to the play-field grid and range-checks it. It then scans the snake body memory for a collision, retrying with fresh samples until a free cell is found or the retry budget runs out. It sits between the random generator, the snake body store and the renderer/collision logic, and holds the current food position.

## Interface

- GRID, 10: cell pitch in pixels.
- X_MIN, 90 / X_MAX, 350: inclusive legal X range for a snapped food cell.
- Y_MIN, 90 / Y_MAX, 350: inclusive legal Y range for a snapped food cell.
- MAX_LEN, 64: snake body memory depth.
- MAX_TRIES, 16: candidate attempts before giving up.
- clk, in, 1: clock clk.
- reset, in, 1: reset reset, asynchronous, active-high.
- spawn_req, in, 1: one-cycle request for a new food position.
- rand_x, in, 10: random X sample.
- rand_y, in, 9: random Y sample.
- snake_len, in, 7: live segment count, 0..MAX_LEN. Sampled at request.
- seg_addr, out, 6: body memory read address.
- seg_x, in, 10: body X at seg_addr. Synchronous read, 1-cycle latency.
- seg_y, in, 9: body Y at seg_addr.
- food_x, out, 10: current food X.
- food_y, out, 9: current food Y.
- food_valid, out, 1: food_x/food_y hold a committed position.
- busy, out, 1: high in every state except IDLE.
- spawn_done, out, 1: one-cycle pulse when the new food is committed.
- spawn_fail, out, 1: one-cycle pulse when MAX_TRIES is exhausted.

## Operation

- **Reset values:** state IDLE, food_x=X_MIN, food_y=Y_MIN, food_valid=0, seg_addr=0, busy=0, spawn_done=0, spawn_fail=0, try count 0.
- **IDLE:** spawn_req=1 latches snake_len (as N), clears the try count and moves to SAMPLE. spawn_req is ignored while busy.
- **SAMPLE:** registers cand_x and cand_y:
  - cand_x = rand_x − ((rand_x − X_MIN) mod GRID).
  - cand_y = rand_y − ((rand_y − Y_MIN) mod GRID).
  - Subtraction is computed one bit wider than the operand.
  - The try count increments.
  - If rand_x < X_MIN, or rand_y < Y_MIN, or the snapped value exceeds X_MAX/Y_MAX, the candidate is rejected: go to RETRY.
  - Otherwise, go to SCAN with seg_addr=0 if N>0, or to COMMIT if N=0.
- **SCAN:** seg_addr increments each cycle from 0 to N−1. Returned data is compared one cycle after its address.
  - Exact match (seg_x==cand_x and seg_y==cand_y) aborts the scan immediately and goes to RETRY.
  - Comparing index N−1 with no hit goes to COMMIT.
- **RETRY (combinational decision, no extra cycle):**
  - If try count < MAX_TRIES, go to SAMPLE.
  - Otherwise go to FAIL.
- **COMMIT:** food_x=cand_x, food_y=cand_y, food_valid=1, spawn_done pulses, return to IDLE.
- **FAIL:** food_valid=0, food_x/food_y keep their old values, spawn_fail pulses, return to IDLE.
- **Body changes:** snake_len changes during a scan are ignored; the latched N is used. Body memory writes during a scan are the caller's responsibility.

## Timing

- Edges are numbered from E0, the edge that samples spawn_req.
- **N=0, first candidate accepted:** SAMPLE at E1. Outputs and spawn_done are visible after E2, so latency is 2 edges.
- **N≥1, no hit:**
  - seg_addr=k is presented after E(1+k).
  - The compare for index k happens at E(3+k).
  - COMMIT is entered at E(N+2); outputs update at E(N+3).
  - Latency is N+3 edges.
- **Hit at index k:** the edge after E(3+k) re-enters SAMPLE; each retry costs at most N+2 edges.
- **Out-of-range sample:** costs exactly 1 edge (SAMPLE → SAMPLE).
- **Pulse width:** spawn_done and spawn_fail are exactly one cycle and mutually exclusive.
- **Back-to-back requests:** spawn_req in the same cycle as spawn_done is ignored; a request is accepted only when busy=0.
- **Reset mid-operation:** any state returns immediately to IDLE with the reset values, including food_valid=0.

## Structure

- Shared package snake_pkg holds:
  - GRID, X_MIN, X_MAX, Y_MIN, Y_MAX and the coordinate widths (X 10, Y 9).
  - The state enum {IDLE, SAMPLE, SCAN, COMMIT, FAIL}.
- One sub-module, grid_snap: combinational snap plus range check for one axis, parameterized by min, max, pitch and width. Instantiate it once per axis.
- The FSM, address counter and try counter live in food_spawner.

## Test plan

1. **Snap, empty body:** reset, N=0, rand=(137,212), pulse spawn_req → after 2 edges food=(130,210), food_valid=1, spawn_done pulses once.
2. **Collision and retry:** N=3, seg[2]=(130,210), rand=(137,212), then rand=(255,101) → the first candidate aborts at the index-2 compare; food=(250,100) committed; seg_addr sequence 0,1,2,0,1,2.
3. **Out-of-range:** rand_x=89, then rand_x=400, then rand=(90,90) → two rejected samples, food=(90,90), total latency 4 edges with N=0.
4. **Exhaustion:** every candidate collides (N=1, seg[0] tracks the snapped rand) → spawn_fail after the 16th try, food_valid=0, food_x/food_y unchanged.
5. **Ignored request:** spawn_req pulsed while busy → ignored; exactly one spawn_done is produced.
6. **Reset mid-scan:** reset asserted at seg_addr=5 with N=20 → IDLE, food=(90,90), food_valid=0. A new request after deassertion completes normally.
